// File: rtl/bilinear_resize_engine_p.sv
// bilinear_resize_engine_p: bilinear upscaler of an SW x SH SRAM region to an OUT_N x OUT_N grid.
// A four-slot pixel cache, indexed by coordinate parity, keeps every pixel of the current 2x2 window.
module bilinear_resize_engine_p #(
  parameter int DW       = 8,
  parameter int IMG_LOG2 = 6,
  parameter int FRAC     = 4,
  parameter int SCW      = 4
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [IMG_LOG2-1:0]   H0,
  input  logic [IMG_LOG2-1:0]   V0,
  input  logic [SCW-1:0]        SW,
  input  logic [SCW-1:0]        SH,
  output logic                  REN,
  output logic [2*IMG_LOG2-1:0] ADDR,
  input  logic [DW-1:0]         R_DATA,
  output logic [DW-1:0]         O_DATA,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);
  localparam int PW = FRAC + SCW;
  localparam int CW = (IMG_LOG2 > SCW ? IMG_LOG2 : SCW) + 1;
  localparam int MW = DW + FRAC + 1;
  localparam int AW = 2 * IMG_LOG2;
  localparam logic [FRAC:0] LAST = (FRAC+1)'(2**FRAC);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, OUT} state_t;

  state_t              r_state;
  logic [IMG_LOG2-1:0] r_h0, r_v0;
  logic [SCW-1:0]      r_sw, r_sh;
  logic [FRAC:0]       r_ox, r_oy;
  logic [PW-1:0]       r_px, r_py;
  logic [3:0]          r_vld;
  logic [AW-1:0]       r_tag [4];
  logic [DW-1:0]       r_pix [4];
  logic                r_pend;
  logic [1:0]          r_pslot;
  logic                r_ovalid, r_busy, r_done, r_err;
  logic [DW-1:0]       r_odata;

  logic                w_bad, w_row_end, w_last, w_more;
  logic [PW-1:0]       w_npx, w_npy, w_spx, w_spy;
  logic [FRAC-1:0]     w_fx, w_fy;
  logic [FRAC:0]       w_wx, w_wy;
  logic [IMG_LOG2-1:0] w_x0, w_x1, w_y0, w_y1;
  logic [3:0]          w_need, w_miss;
  logic [AW-1:0]       w_pa [4];
  logic [1:0]          w_slot [4];
  logic [1:0]          w_k;
  logic [DW-1:0]       w_top, w_bot, w_res;

  assign w_bad = (SW == '0) || (SH == '0) ||
                 (CW'(H0) + CW'(SW) > CW'(2**IMG_LOG2)) ||
                 (CW'(V0) + CW'(SH) > CW'(2**IMG_LOG2));

  // In OUT the window logic looks ahead at the next output so the hit/miss decision lands on the handshake edge.
  always_comb begin
    w_row_end = (r_ox == LAST);
    w_last    = w_row_end && (r_oy == LAST);
    w_npx     = w_row_end ? '0 : r_px + PW'(r_sw - 1'b1);
    w_npy     = w_row_end ? r_py + PW'(r_sh - 1'b1) : r_py;
    w_spx     = (r_state == OUT) ? w_npx : r_px;
    w_spy     = (r_state == OUT) ? w_npy : r_py;
    w_fx      = w_spx[FRAC-1:0];
    w_fy      = w_spy[FRAC-1:0];
    w_x0      = IMG_LOG2'(CW'(r_h0) + CW'(w_spx[PW-1:FRAC]));
    w_y0      = IMG_LOG2'(CW'(r_v0) + CW'(w_spy[PW-1:FRAC]));
    w_x1      = w_x0 + 1'b1;
    w_y1      = w_y0 + 1'b1;
    w_need    = {(|w_fx) && (|w_fy), |w_fy, |w_fx, 1'b1};
    for (int k = 0; k < 4; k++) begin
      w_pa[k]   = {(k >= 2) ? w_y1 : w_y0, (k % 2 == 1) ? w_x1 : w_x0};
      w_slot[k] = {w_pa[k][IMG_LOG2], w_pa[k][0]};
      w_miss[k] = w_need[k] && !(r_vld[w_slot[k]] && r_tag[w_slot[k]] == w_pa[k]);
    end
    w_k    = w_miss[0] ? 2'd0 : w_miss[1] ? 2'd1 : w_miss[2] ? 2'd2 : 2'd3;
    w_more = |(w_miss & ~(4'b0001 << w_k));
    w_wx   = LAST - {1'b0, w_fx};
    w_wy   = LAST - {1'b0, w_fy};
    w_top  = DW'((MW'(r_pix[w_slot[0]]) * MW'(w_wx) + MW'(r_pix[w_slot[1]]) * MW'(w_fx)) >> FRAC);
    w_bot  = DW'((MW'(r_pix[w_slot[2]]) * MW'(w_wx) + MW'(r_pix[w_slot[3]]) * MW'(w_fx)) >> FRAC);
    w_res  = DW'((MW'(w_top) * MW'(w_wy) + MW'(w_bot) * MW'(w_fy)) >> FRAC);
  end

  assign REN     = (r_state != FETCH);
  assign ADDR    = (r_state == FETCH) ? w_pa[w_k] : '0;
  assign O_DATA  = r_odata;
  assign O_VALID = r_ovalid;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_h0     <= '0;
      r_v0     <= '0;
      r_sw     <= '0;
      r_sh     <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_vld    <= '0;
      r_pend   <= 1'b0;
      r_pslot  <= '0;
      r_ovalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_odata  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_tag[i] <= '0;
        r_pix[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_pend <= 1'b0;
      if (r_pend) r_pix[r_pslot] <= R_DATA;
      case (r_state)
        IDLE: if (START) begin
          if (w_bad) r_err <= 1'b1;
          else begin
            r_h0    <= H0;
            r_v0    <= V0;
            r_sw    <= SW;
            r_sh    <= SH;
            r_ox    <= '0;
            r_oy    <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_vld   <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        // The slot tag is claimed at issue time; its data lands one cycle later via r_pend.
        FETCH: begin
          r_tag[w_slot[w_k]] <= w_pa[w_k];
          r_vld[w_slot[w_k]] <= 1'b1;
          r_pend             <= 1'b1;
          r_pslot            <= w_slot[w_k];
          if (!w_more) r_state <= WAIT;
        end
        WAIT: r_state <= CALC;
        CALC: begin
          r_odata  <= w_res;
          r_ovalid <= 1'b1;
          r_state  <= OUT;
        end
        OUT: if (O_READY) begin
          r_ovalid <= 1'b0;
          if (w_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_ox    <= w_row_end ? '0 : r_ox + 1'b1;
            r_oy    <= w_row_end ? r_oy + 1'b1 : r_oy;
            r_px    <= w_npx;
            r_py    <= w_npy;
            r_state <= (|w_miss) ? FETCH : CALC;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
